// File: rtl/decode_stage.sv
// ID stage of the 5-stage MIPS32 pipeline: IF/ID register, 32-entry register file,
// main control decode, sign-extension and load-use hazard detection.
module decode_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_next,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    output logic              pc_en,
    output logic [31:0]       id_pc,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              reg_dst,
    output logic              branch,
    output logic              jump,
    output logic [1:0]        alu_op,
    output logic              illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [NREG];

    logic [5:0] opcode;
    logic       uses_rt;
    logic       hz;
    logic       stall;
    logic       wb_hit;

    assign opcode  = instr_q[31:26];
    assign rs      = instr_q[25:21];
    assign rt      = instr_q[20:16];
    assign rd      = instr_q[15:11];
    assign imm_ext = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign id_pc   = pc_q;

    // Only instructions that actually read rt can be hurt by a load into rt.
    assign uses_rt = (opcode == OP_RTYPE) | (opcode == OP_BEQ) | (opcode == OP_SW);
    assign hz      = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == rs) | ((ex_rt == rt) & uses_rt));
    assign pc_en   = rst | flush | ~hz;
    assign stall   = ~pc_en;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'd0;
        end else if (pc_en) begin
            instr_d = instruction;
            pc_d    = pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign wb_hit = wb_en & (wb_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (wb_hit) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Write-through bypass lets WB and ID share a cycle without a separate forward path.
    always_comb begin
        rs_data = regs_q[rs];
        if (rs == 5'd0)                  rs_data = '0;
        else if (wb_hit && wb_addr == rs) rs_data = wb_data;
        rt_data = regs_q[rt];
        if (rt == 5'd0)                  rt_data = '0;
        else if (wb_hit && wb_addr == rt) rt_data = wb_data;
    end

    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                mem_read   = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_J:    jump    = 1'b1;
            default: illegal = 1'b1;
        endcase
        // Held instruction is re-presented next cycle; this cycle becomes a bubble.
        if (stall) begin
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            alu_src    = 1'b0;
            reg_dst    = 1'b0;
            branch     = 1'b0;
            jump       = 1'b0;
            alu_op     = 2'b00;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: directed scenarios then random traffic,
// checked against a pipeline-level reference model held in the bench.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0, pc_next = '0;
    logic        flush = 1'b0, wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;

    logic        pc_en;
    logic [31:0] id_pc, rs_data, rt_data, imm_ext;
    logic [4:0]  rs, rt, rd;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump;
    logic [1:0]  alu_op;
    logic        illegal;

    decode_stage dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_next(pc_next), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .pc_en(pc_en), .id_pc(id_pc), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .rs(rs), .rt(rt), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_dst(reg_dst),
        .branch(branch), .jump(jump), .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          all;
        logic        pc_en;
        logic [31:0] id_pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
        logic [1:0]  alu_op;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference pipeline state: what the ID stage should be holding.
    logic [31:0] m_instr, m_pc;
    logic [31:0] m_rf [32];
    bit          m_known = 0;

    // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump}
    function automatic void ref_decode(input logic [5:0] op, output logic [7:0] c,
                                       output logic [1:0] a, output logic ill);
        c = 8'b0; a = 2'b00; ill = 1'b0;
        case (op)
            6'h00: begin c = 8'b1000_0100; a = 2'b10; end
            6'h23: c = 8'b1101_1000;
            6'h2B: c = 8'b0010_1000;
            6'h04: begin c = 8'b0000_0010; a = 2'b01; end
            6'h08: c = 8'b1000_1000;
            6'h02: c = 8'b0000_0001;
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    task automatic cyc(input logic r, input logic [31:0] ins, input logic [31:0] pcn,
                       input logic fl, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic exr, input logic [4:0] ext);
        exp_t        e;
        logic [5:0]  op;
        logic [4:0]  f_rs, f_rt;
        logic        hz, stall, user;
        @(posedge clk);
        #1;
        rst = r; instruction = ins; pc_next = pcn; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; ex_mem_read = exr; ex_rt = ext;

        op   = m_instr[31:26];
        f_rs = m_instr[25:21];
        f_rt = m_instr[20:16];
        user = (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
        hz   = exr && ext != 0 && (ext == f_rs || (ext == f_rt && user));
        e.all   = m_known;
        e.pc_en = r || fl || !hz;
        stall   = !e.pc_en;
        e.id_pc = m_pc;
        e.rs = f_rs; e.rt = f_rt; e.rd = m_instr[15:11];
        e.imm = 32'($signed(m_instr[15:0]));
        e.rs_data = ref_read(f_rs, we, wa, wd);
        e.rt_data = ref_read(f_rt, we, wa, wd);
        ref_decode(op, e.ctrl, e.alu_op, e.illegal);
        if (stall) begin e.ctrl = '0; e.alu_op = '0; e.illegal = 1'b0; end
        exp_q.push_back(e);

        if (r) begin
            m_instr = 32'd0; m_pc = 32'd0; m_known = 1;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (fl) begin m_instr = 32'd0; m_pc = 32'd0; end
            else if (!stall) begin m_instr = ins; m_pc = pcn; end
            if (we && wa != 0) m_rf[wa] = wd;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_en", 32'(pc_en), 32'(e.pc_en));
            if (e.all) begin
                chk("id_pc", id_pc, e.id_pc);
                chk("rs_data", rs_data, e.rs_data);
                chk("rt_data", rt_data, e.rt_data);
                chk("imm_ext", imm_ext, e.imm);
                chk("rs_rt_rd", {17'd0, rs, rt, rd}, {17'd0, e.rs, e.rt, e.rd});
                chk("ctrl", 32'({reg_write, mem_read, mem_write, mem_to_reg,
                                 alu_src, reg_dst, branch, jump}), 32'(e.ctrl));
                chk("alu_op", 32'(alu_op), 32'(e.alu_op));
                chk("illegal", 32'(illegal), 32'(e.illegal));
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h08;
            5: op = 6'h02;
            default: op = 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    initial begin
        // reset, bypass, r0 write
        cyc(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'h00A0_0020, 32'h104, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'h0000_0020, 32'h108, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        cyc(0, 32'h0100_0020, 32'h10C, 0, 1, 0, 32'h7, 0, 0);
        // load-use stall and release
        cyc(0, 32'h2068_0005, 32'h110, 0, 0, 0, 0, 1, 8);
        cyc(0, 32'h2068_0005, 32'h110, 0, 0, 0, 0, 0, 0);
        // addi with rt=8 and ex_rt=0 cases: no stall
        cyc(0, 32'h0000_0020, 32'h114, 0, 0, 0, 0, 1, 8);
        cyc(0, 32'h0100_0020, 32'h118, 0, 0, 0, 0, 1, 0);
        // stall and flush together
        cyc(0, 32'h8C88_0010, 32'h11C, 1, 0, 0, 0, 1, 8);
        // lw, negative immediate, illegal opcode
        cyc(0, 32'h8C88_0010, 32'h11C, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'h2000_FFFC, 32'h120, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'hFC00_0000, 32'h124, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'h0100_0020, 32'h128, 0, 0, 0, 0, 0, 0);
        // reset arriving mid-stall
        cyc(0, 32'h0000_0020, 32'h12C, 0, 0, 0, 0, 1, 8);
        cyc(1, 32'h0000_0020, 32'h12C, 0, 0, 0, 0, 1, 8);
        cyc(0, 32'h0000_0020, 32'h130, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) == 0, rand_instr(), $urandom,
                $urandom_range(0, 9) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
                $urandom, $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
